// File: rtl/gat_feat_argmax.sv
// gat_feat_argmax: per-node argmax readout of the final-layer feature BRAM.
//
// After a sampled `start`, the block walks nodes 0..NUM_SUBGRAPHS-1. For each node it
// reads NUM_FEATURE_FINAL signed logits through the byte-addressed BRAM port. It then
// presents one label (node index + winning class) on a valid/ready stream.
//
// Optional feature macro: GAT_ARGMAX_MAXVAL_EN adds the lbl_max port (winning logit).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level, sampled only while idle
//   feat_bram_addrb   byte address (word address << 2) to the feature BRAM
//   feat_bram_dout    signed feature word, RD_LATENCY cycles after the address
//   lbl_valid/ready   label stream handshake
//   lbl_node          node index of the presented label
//   lbl_class         argmax class (ties resolve to the lowest index)
//   lbl_max           winning logit (only with GAT_ARGMAX_MAXVAL_EN)
//   busy              high from start acceptance until done
//   done              one-cycle pulse at the end of a pass
module gat_feat_argmax #(
  parameter int unsigned NEW_FEATURE_WIDTH = 32,
  parameter int unsigned NUM_SUBGRAPHS     = 2708,
  parameter int unsigned NUM_FEATURE_FINAL = 7,
  parameter int unsigned RD_LATENCY        = 2,
  parameter int unsigned FEAT_ADDR_W       = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_FINAL),
  parameter int unsigned NODE_IDX_W        = $clog2(NUM_SUBGRAPHS),
  parameter int unsigned CLASS_W           = $clog2(NUM_FEATURE_FINAL)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [FEAT_ADDR_W+1:0]       feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  output logic                         lbl_valid,
  input  logic                         lbl_ready,
  output logic [NODE_IDX_W-1:0]        lbl_node,
  output logic [CLASS_W-1:0]           lbl_class,
`ifdef GAT_ARGMAX_MAXVAL_EN
  output logic [NEW_FEATURE_WIDTH-1:0] lbl_max,
`endif
  output logic                         busy,
  output logic                         done
);

  localparam logic [CLASS_W-1:0]     KLast    = CLASS_W'(NUM_FEATURE_FINAL - 1);
  localparam logic [NODE_IDX_W-1:0]  NodeLast = NODE_IDX_W'(NUM_SUBGRAPHS - 1);
  localparam logic [FEAT_ADDR_W-1:0] FStep    = FEAT_ADDR_W'(NUM_FEATURE_FINAL);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StOut, StDone} state_e;

  state_e state_q, state_d;

  logic [NODE_IDX_W-1:0]        node_q, node_d;
  logic [FEAT_ADDR_W-1:0]       base_q, base_d;
  logic [FEAT_ADDR_W-1:0]       addr_q, addr_d;
  logic [CLASS_W-1:0]           k_q, k_d;
  logic [NEW_FEATURE_WIDTH-1:0] max_q, max_d;
  logic [CLASS_W-1:0]           class_q, class_d;

  // Tag pipeline: follows each issued address until its data word returns.
  logic [RD_LATENCY-1:0]              tag_vld_q;
  logic [RD_LATENCY-1:0][CLASS_W-1:0] tag_idx_q;

  logic issue, ret_vld, last_word, hs;
  logic [CLASS_W-1:0] ret_idx;

  assign issue     = (state_q == StRead);
  assign ret_vld   = tag_vld_q[RD_LATENCY-1];
  assign ret_idx   = tag_idx_q[RD_LATENCY-1];
  assign last_word = ret_vld && (ret_idx == KLast);
  assign hs        = (state_q == StOut) && lbl_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (k_q == KLast) state_d = StWait;
      StWait:  if (last_word) state_d = StOut;
      StOut:   if (lbl_ready) state_d = (node_q == NodeLast) ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    lbl_valid = (state_q == StOut);
    busy      = (state_q == StRead) || (state_q == StWait) || (state_q == StOut);
    done      = (state_q == StDone);
  end

  assign feat_bram_addrb = {addr_q, 2'b00};
  assign lbl_node        = node_q;
  assign lbl_class       = class_q;
`ifdef GAT_ARGMAX_MAXVAL_EN
  assign lbl_max         = max_q;
`endif

  // Address walk: the base accumulator steps by F per node, so no multiplier is needed.
  always_comb begin
    node_d = node_q;
    base_d = base_q;
    addr_d = addr_q;
    k_d    = k_q;
    if (state_q == StIdle && start) begin
      node_d = '0;
      base_d = '0;
      addr_d = '0;
      k_d    = '0;
    end else if (state_q == StRead && k_q != KLast) begin
      addr_d = addr_q + 1'b1;
      k_d    = k_q + 1'b1;
    end else if (hs && node_q != NodeLast) begin
      node_d = node_q + 1'b1;
      base_d = base_q + FStep;
      addr_d = base_q + FStep;
      k_d    = '0;
    end
  end

  // Running argmax; strict signed compare keeps the lowest index on ties.
  always_comb begin
    max_d   = max_q;
    class_d = class_q;
    if (ret_vld) begin
      if (ret_idx == '0) begin
        max_d   = feat_bram_dout;
        class_d = '0;
      end else if ($signed(feat_bram_dout) > $signed(max_q)) begin
        max_d   = feat_bram_dout;
        class_d = ret_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      k_q       <= '0;
      max_q     <= '0;
      class_q   <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      node_q       <= node_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      k_q          <= k_d;
      max_q        <= max_d;
      class_q      <= class_d;
      tag_vld_q[0] <= issue;
      tag_idx_q[0] <= k_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule

// File: doc/gat_feat_argmax.md
# gat_feat_argmax

Downstream classification stage for the GAT accelerator. After `gat_top` asserts `gat_ready`, this block walks the final-layer feature BRAM through its byte-addressed read port. For each node it reads `NUM_FEATURE_FINAL` signed logits, selects the argmax class, and emits one label per node on a valid/ready stream. It replaces host-side readout of `feat_bram_dout` when only class labels are needed.

## Interface
Parameters:
- `NEW_FEATURE_WIDTH`, 32: width of one signed feature word on `feat_bram_dout`.
- `NUM_SUBGRAPHS`, 2708: number of nodes to classify (one output row per subgraph).
- `NUM_FEATURE_FINAL`, 7: logits per node (F).
- `RD_LATENCY`, 2: BRAM read latency in cycles from the address to valid `dout`. Must be ≥ 1.
- `FEAT_ADDR_W`, `$clog2(NUM_SUBGRAPHS*NUM_FEATURE_FINAL)`: word address width.
- `NODE_IDX_W`, `$clog2(NUM_SUBGRAPHS)`: node index width.
- `CLASS_W`, `$clog2(NUM_FEATURE_FINAL)`: class index width.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled in IDLE; a high sample begins a pass.
- `feat_bram_addrb` output `FEAT_ADDR_W+2`: byte address, equal to word address << 2; bits [1:0] are always 0.
- `feat_bram_dout` input `NEW_FEATURE_WIDTH`: signed two's-complement feature word.
- `lbl_valid` output 1: a label is available.
- `lbl_ready` input 1: the consumer accepts the label.
- `lbl_node` output `NODE_IDX_W`: node index of the current label.
- `lbl_class` output `CLASS_W`: argmax class of the current label.
- `lbl_max` output `NEW_FEATURE_WIDTH`: winning logit. Present only with `GAT_ARGMAX_MAXVAL_EN`.
- `busy` output 1: high from the start acceptance until `done`.
- `done` output 1: one-cycle pulse at the end of a pass.

## Operation
States:
- **IDLE**: if `start` is high, latch node=0, raise `busy`, go to READ.
- **READ**: issue word address `node*F + k` for k=0..F-1, one per cycle. After k=F-1, go to WAIT.
- **WAIT**: hold for the read pipeline. When the F-th data word has been consumed, go to OUT.
- **OUT**: hold `lbl_valid`, `lbl_node` and `lbl_class` stable until `lbl_ready`. On the handshake:
  - if node = `NUM_SUBGRAPHS`-1, go to DONE;
  - otherwise node++ and go to READ.
- **DONE**: pulse `done`, clear `busy`, go to IDLE.

Data tracking:
- A `RD_LATENCY`-deep valid/index shift register tags each issued address.
- When a returning word's tag index is k:
  - k=0 loads the running max and sets class 0;
  - k>0 replaces the max and class only if `dout` > max, compared signed and strict.
- Strict comparison means ties keep the lowest class index. All-equal logits yield class 0.
- The base address `node*F` is held in an accumulator incremented by F per node; no multiplier.
- `feat_bram_addrb` holds its last value outside READ.

Boundaries:
- `start` is ignored while `busy` is high.
- `lbl_ready` held high still costs one handshake cycle per node; there is no overlap between nodes.
- The most negative value (0x80000000) as the only nonzero logit with the others at 0 → a zero-valued class wins; the lowest such index is chosen.
- `NUM_SUBGRAPHS`=1: a single label, then `done`.
- Address wraps are impossible by construction; the last word is `NUM_SUBGRAPHS*F-1`.

## Timing
- Reset values: `feat_bram_addrb`=0, `lbl_valid`=0, `lbl_node`=0, `lbl_class`=0, `lbl_max`=0, `busy`=0, `done`=0. State=IDLE.
- Reset mid-pass aborts immediately. The pipeline is flushed, no label or `done` is emitted, and a fresh `start` restarts from node 0.
- `start` sampled high at edge 0 → `busy`=1 and the first address are driven after edge 0.
- Per node, the first address cycle to `lbl_valid` rising is F+`RD_LATENCY` cycles (9 at defaults).
- The handshake at edge h starts the next node's first address in cycle h+1.
- After the last handshake, `done` is high for exactly one cycle. `busy` falls in the same cycle.
- Total pass with `lbl_ready` tied high: `NUM_SUBGRAPHS`*(F+`RD_LATENCY`+1)+2 cycles.

## Configuration
- `GAT_ARGMAX_MAXVAL_EN` defined: the `lbl_max` port exists and carries the winning signed logit, stable with `lbl_valid`.
- Not defined: the port and its register are removed. Class selection is unchanged.

## Test plan
- 1 node, logits {3,-5,9,9,0,1,2}, `lbl_ready`=1 → label node 0, class 2; `lbl_max`=9; `lbl_valid` 9 cycles after the first address; `done` pulses once.
- All logits negative {-8,-2,-7,-2,-9,-3,-4} → class 1. With the macro, `lbl_max`=0xFFFFFFFE.
- 4 nodes, `lbl_ready` toggling 1-in-3 → labels in order 0..3 with outputs stable while stalled; addresses 0..27 (bytes 0..108) each issued exactly once.
- `start` pulsed mid-pass → ignored; label count stays `NUM_SUBGRAPHS`.
- `rst_n` low during WAIT of node 2 → all outputs return to reset values asynchronously. A restart yields node 0 first.
- `RD_LATENCY`=1 and 3 builds → per-node latency of 8 and 10 respectively; classes unchanged.
